// File: rtl/coin_manager.sv
// Coin slot table with collision-driven collect FSM, two-digit BCD coin counter
// and a rising "pop" sprite that animates each collected coin for a few frames.
module coin_manager #(
   parameter int N_COINS    = 8,
   parameter int POP_FRAMES = 8,
   parameter int POP_STEP   = 4,
   localparam int IDX_W     = $clog2(N_COINS)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             frame_tick,
   input  logic             load_en,
   input  logic [IDX_W-1:0] load_idx,
   input  logic [31:0]      load_coord,
   input  logic             col_valid,
   input  logic [IDX_W-1:0] col_idx,
   output logic             col_ready,
   input  logic [IDX_W-1:0] rd_idx,
   output logic [31:0]      rd_coord,
   output logic [31:0]      rd_size,
   output logic             rd_enable,
   output logic [7:0]       coin_count,
   output logic             life_pulse,
   output logic             pop_active,
   output logic [31:0]      pop_coord
);

   localparam int CNT_W = $clog2(POP_FRAMES + 1);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] CLEAR = 2'd1;
   localparam logic [1:0] COUNT = 2'd2;

   logic [1:0]       state;
   logic [31:0]      coord [N_COINS];
   logic [N_COINS-1:0] enable;
   logic [IDX_W-1:0] lat_idx;
   logic [31:0]      lat_coord;
   logic [CNT_W-1:0] pop_cnt;

   logic load_ok, col_ok, rd_ok, handshake, hit;

   assign load_ok   = int'(load_idx) < N_COINS;
   assign col_ok    = int'(col_idx) < N_COINS;
   assign rd_ok     = int'(rd_idx) < N_COINS;
   assign col_ready = (state == IDLE) && !load_en && !rst;
   assign handshake = col_valid && col_ready;
   assign hit       = handshake && col_ok && enable[col_idx];

   // Loads are applied after the CLEAR write so a same-cycle reload of the slot wins.
   always_ff @(posedge clk) begin
      if (rst) begin
         enable <= '0;
      end else begin
         if (state == CLEAR)
            enable[lat_idx] <= 1'b0;
         if (load_en && load_ok) begin
            enable[load_idx] <= 1'b1;
            coord[load_idx]  <= load_coord;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst || !rd_ok || !enable[rd_idx]) begin
         rd_coord  <= 32'hFFFF_FFFF;
         rd_size   <= 32'h0;
         rd_enable <= 1'b0;
      end else begin
         rd_coord  <= coord[rd_idx];
         rd_size   <= {16'd16, 16'd16};
         rd_enable <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         lat_idx   <= '0;
         lat_coord <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (hit) begin
                  state     <= CLEAR;
                  lat_idx   <= col_idx;
                  lat_coord <= coord[col_idx];
               end
            end
            CLEAR:   state <= COUNT;
            default: state <= IDLE;
         endcase
      end
   end

   // BCD increment; the wrap from 99 to 00 awards a life.
   always_ff @(posedge clk) begin
      if (rst) begin
         coin_count <= 8'h00;
         life_pulse <= 1'b0;
      end else begin
         life_pulse <= 1'b0;
         if (state == COUNT) begin
            if (coin_count[3:0] == 4'd9) begin
               coin_count[3:0] <= 4'd0;
               if (coin_count[7:4] == 4'd9) begin
                  coin_count[7:4] <= 4'd0;
                  life_pulse      <= 1'b1;
               end else begin
                  coin_count[7:4] <= coin_count[7:4] + 4'd1;
               end
            end else begin
               coin_count[3:0] <= coin_count[3:0] + 4'd1;
            end
         end
      end
   end

   // A pop start overrides any frame tick arriving in the same cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         pop_active <= 1'b0;
         pop_coord  <= 32'hFFFF_FFFF;
         pop_cnt    <= '0;
      end else if (state == CLEAR) begin
         pop_active <= 1'b1;
         pop_coord  <= lat_coord;
         pop_cnt    <= '0;
      end else if (frame_tick && pop_active) begin
         if (pop_cnt == CNT_W'(POP_FRAMES - 1)) begin
            pop_active <= 1'b0;
            pop_coord  <= 32'hFFFF_FFFF;
            pop_cnt    <= '0;
         end else begin
            pop_coord[15:0] <= pop_coord[15:0] - 16'(POP_STEP);
            pop_cnt         <= pop_cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_coin_manager.sv
// Directed testbench for coin_manager: slot load/read, collect sequence, pop
// animation, BCD wrap with life pulse and reset during a collect.
module tb_coin_manager;

   logic        clk;
   logic        rst;
   logic        frame_tick;
   logic        load_en;
   logic [2:0]  load_idx;
   logic [31:0] load_coord;
   logic        col_valid;
   logic [2:0]  col_idx;
   logic        col_ready;
   logic [2:0]  rd_idx;
   logic [31:0] rd_coord;
   logic [31:0] rd_size;
   logic        rd_enable;
   logic [7:0]  coin_count;
   logic        life_pulse;
   logic        pop_active;
   logic [31:0] pop_coord;

   int testsRun;
   int testsFailed;

   logic [15:0] popY [7];

   coin_manager dut (
      .clk        (clk),
      .rst        (rst),
      .frame_tick (frame_tick),
      .load_en    (load_en),
      .load_idx   (load_idx),
      .load_coord (load_coord),
      .col_valid  (col_valid),
      .col_idx    (col_idx),
      .col_ready  (col_ready),
      .rd_idx     (rd_idx),
      .rd_coord   (rd_coord),
      .rd_size    (rd_size),
      .rd_enable  (rd_enable),
      .coin_count (coin_count),
      .life_pulse (life_pulse),
      .pop_active (pop_active),
      .pop_coord  (pop_coord)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      testsRun++;
      if (observed !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
      end
   endtask

   // Advance a number of clock edges; inputs change and outputs are sampled 1ns after the edge.
   task automatic step(input int cycles);
      repeat (cycles) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Load a slot and then collide with it, returning once the FSM is back in IDLE.
   task automatic applyStimulus(input logic [2:0] idx, input logic [31:0] c);
      load_en    = 1'b1;
      load_idx   = idx;
      load_coord = c;
      step(1);
      load_en   = 1'b0;
      col_valid = 1'b1;
      col_idx   = idx;
      step(1);
      col_valid = 1'b0;
      step(2);
   endtask

   initial begin
      testsRun    = 0;
      testsFailed = 0;
      popY[0] = 16'h00C4; popY[1] = 16'h00C0; popY[2] = 16'h00BC; popY[3] = 16'h00B8;
      popY[4] = 16'h00B4; popY[5] = 16'h00B0; popY[6] = 16'h00AC;
      rst = 1'b1; frame_tick = 1'b0; load_en = 1'b0; load_idx = '0; load_coord = '0;
      col_valid = 1'b0; col_idx = '0; rd_idx = 3'd3;
      step(2);
      checkOutput("rst col_ready", 32'(col_ready), 32'd0);
      checkOutput("rst rd_coord", rd_coord, 32'hFFFF_FFFF);
      checkOutput("rst rd_size", rd_size, 32'h0);
      checkOutput("rst rd_enable", 32'(rd_enable), 32'd0);
      checkOutput("rst coin_count", 32'(coin_count), 32'h00);
      checkOutput("rst life_pulse", 32'(life_pulse), 32'd0);
      checkOutput("rst pop_active", 32'(pop_active), 32'd0);
      checkOutput("rst pop_coord", pop_coord, 32'hFFFF_FFFF);
      rst = 1'b0;

      // Load slot 3 at (100,200); col_ready must drop while a load is pending.
      load_en = 1'b1; load_idx = 3'd3; load_coord = 32'h0064_00C8;
      col_valid = 1'b1; col_idx = 3'd3;
      #1;
      checkOutput("col_ready during load", 32'(col_ready), 32'd0);
      step(1);
      load_en = 1'b0; col_valid = 1'b0;
      step(1);
      checkOutput("load rd_coord", rd_coord, 32'h0064_00C8);
      checkOutput("load rd_size", rd_size, 32'h0010_0010);
      checkOutput("load rd_enable", 32'(rd_enable), 32'd1);

      // Collect slot 3.
      col_valid = 1'b1; col_idx = 3'd3;
      #1;
      checkOutput("idle col_ready", 32'(col_ready), 32'd1);
      step(1);
      col_valid = 1'b0;
      checkOutput("clear col_ready", 32'(col_ready), 32'd0);
      step(1);
      checkOutput("count col_ready", 32'(col_ready), 32'd0);
      checkOutput("count coin_count", 32'(coin_count), 32'h00);
      checkOutput("pop start active", 32'(pop_active), 32'd1);
      checkOutput("pop start coord", pop_coord, 32'h0064_00C8);
      step(1);
      checkOutput("collect coin_count", 32'(coin_count), 32'h01);
      checkOutput("collect rd_enable", 32'(rd_enable), 32'd0);
      checkOutput("collect rd_coord", rd_coord, 32'hFFFF_FFFF);
      checkOutput("collect col_ready", 32'(col_ready), 32'd1);

      // Pop animation over eight frame ticks.
      for (int i = 0; i < 8; i++) begin
         frame_tick = 1'b1;
         step(1);
         frame_tick = 1'b0;
         if (i < 7) begin
            checkOutput($sformatf("pop y tick %0d", i + 1), pop_coord, {16'h0064, popY[i]});
            checkOutput($sformatf("pop active tick %0d", i + 1), 32'(pop_active), 32'd1);
         end else begin
            checkOutput("pop end coord", pop_coord, 32'hFFFF_FFFF);
            checkOutput("pop end active", 32'(pop_active), 32'd0);
         end
         step(1);
      end

      // Collision on the now-disabled slot 3 is consumed without effect.
      col_valid = 1'b1; col_idx = 3'd3;
      step(1);
      col_valid = 1'b0;
      checkOutput("disabled hit col_ready", 32'(col_ready), 32'd1);
      step(2);
      checkOutput("disabled hit count", 32'(coin_count), 32'h01);
      checkOutput("disabled hit pop", 32'(pop_active), 32'd0);

      // Reload of the slot during CLEAR wins; the count still increments.
      rd_idx = 3'd5;
      load_en = 1'b1; load_idx = 3'd5; load_coord = 32'h0010_0020;
      step(1);
      load_en = 1'b0; col_valid = 1'b1; col_idx = 3'd5;
      step(1);
      col_valid = 1'b0;
      load_en = 1'b1; load_idx = 3'd5; load_coord = 32'h0030_0040;
      step(1);
      load_en = 1'b0;
      checkOutput("load-wins pop coord", pop_coord, 32'h0010_0020);
      step(1);
      checkOutput("load-wins rd_coord", rd_coord, 32'h0030_0040);
      checkOutput("load-wins rd_enable", 32'(rd_enable), 32'd1);
      checkOutput("load-wins count", 32'(coin_count), 32'h02);

      // Restart an active pop; a tick coinciding with the start is ignored.
      frame_tick = 1'b1;
      step(1);
      frame_tick = 1'b0;
      checkOutput("pre-restart y", pop_coord, 32'h0010_001C);
      col_valid = 1'b1; col_idx = 3'd5;
      step(1);
      col_valid = 1'b0; frame_tick = 1'b1;
      step(1);
      frame_tick = 1'b0;
      checkOutput("restart pop coord", pop_coord, 32'h0030_0040);
      checkOutput("restart pop active", 32'(pop_active), 32'd1);
      step(1);
      checkOutput("restart count", 32'(coin_count), 32'h03);

      // Run the count up to 99, then wrap.
      for (int i = 0; i < 96; i++)
         applyStimulus(3'd1, 32'h0001_0001);
      checkOutput("count 99", 32'(coin_count), 32'h99);
      load_en = 1'b1; load_idx = 3'd1; load_coord = 32'h0001_0001;
      step(1);
      load_en = 1'b0; col_valid = 1'b1; col_idx = 3'd1;
      step(1);
      col_valid = 1'b0;
      step(1);
      checkOutput("pre-wrap life_pulse", 32'(life_pulse), 32'd0);
      step(1);
      checkOutput("wrap count", 32'(coin_count), 32'h00);
      checkOutput("wrap life_pulse", 32'(life_pulse), 32'd1);
      step(1);
      checkOutput("post-wrap life_pulse", 32'(life_pulse), 32'd0);

      // Reset asserted while in CLEAR aborts the collect.
      rd_idx = 3'd2;
      load_en = 1'b1; load_idx = 3'd2; load_coord = 32'h0002_0002;
      step(1);
      load_en = 1'b0; col_valid = 1'b1; col_idx = 3'd2;
      step(1);
      col_valid = 1'b0; rst = 1'b1;
      step(1);
      checkOutput("abort col_ready", 32'(col_ready), 32'd0);
      checkOutput("abort count", 32'(coin_count), 32'h00);
      checkOutput("abort pop_active", 32'(pop_active), 32'd0);
      checkOutput("abort pop_coord", pop_coord, 32'hFFFF_FFFF);
      checkOutput("abort rd_enable", 32'(rd_enable), 32'd0);
      rst = 1'b0;
      step(2);
      checkOutput("abort count later", 32'(coin_count), 32'h00);
      checkOutput("abort slot disabled", 32'(rd_enable), 32'd0);
      checkOutput("abort no pop", 32'(pop_active), 32'd0);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
